// File: rtl/psum_accumulator.sv
// Column-bottom partial-sum accumulator: sums psum beats over several weight
// tiles into a per-row buffer, then drains the finished rows over valid/ready.
module psum_accumulator #(
    parameter int PSUM_WIDTH = 32,
    parameter int ACC_WIDTH  = 32,
    parameter int DEPTH      = 16,
    parameter int TILE_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [TILE_WIDTH-1:0] num_tiles_i,
    input  logic [PSUM_WIDTH-1:0] psum_i,
    input  logic                  psum_en_i,
    output logic [ACC_WIDTH-1:0]  out_data_o,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_ROW = PTR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                state_reg, state_next;
    logic [PTR_W-1:0]      row_ptr_reg, row_ptr_next;
    logic [PTR_W-1:0]      rd_ptr_reg, rd_ptr_next;
    logic [TILE_WIDTH-1:0] tile_ptr_reg, tile_ptr_next;
    logic [TILE_WIDTH-1:0] num_tiles_reg, num_tiles_next;
    logic                  done_reg, done_next;
    logic                  acc_we;

    logic [ACC_WIDTH-1:0]  acc_buf [DEPTH];
    logic [ACC_WIDTH-1:0]  psum_ext;
    logic [ACC_WIDTH-1:0]  acc_sum;

    assign psum_ext = ACC_WIDTH'(psum_i);
    // The first tile overwrites the row, so the buffer never needs clearing.
    assign acc_sum  = (tile_ptr_reg == '0) ? psum_ext : acc_buf[row_ptr_reg] + psum_ext;

    always_comb begin
        state_next     = state_reg;
        row_ptr_next   = row_ptr_reg;
        rd_ptr_next    = rd_ptr_reg;
        tile_ptr_next  = tile_ptr_reg;
        num_tiles_next = num_tiles_reg;
        done_next      = 1'b0;
        acc_we         = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start_i && (num_tiles_i != '0)) begin
                    state_next     = ACCUM;
                    num_tiles_next = num_tiles_i;
                    row_ptr_next   = '0;
                    tile_ptr_next  = '0;
                    rd_ptr_next    = '0;
                end
            end
            ACCUM: begin
                if (psum_en_i) begin
                    acc_we = 1'b1;
                    if (row_ptr_reg == LAST_ROW) begin
                        row_ptr_next  = '0;
                        tile_ptr_next = tile_ptr_reg + TILE_WIDTH'(1);
                        if (tile_ptr_reg == num_tiles_reg - TILE_WIDTH'(1)) begin
                            state_next = DRAIN;
                        end
                    end else begin
                        row_ptr_next = row_ptr_reg + PTR_W'(1);
                    end
                end
            end
            DRAIN: begin
                if (out_ready_i) begin
                    if (rd_ptr_reg == LAST_ROW) begin
                        state_next  = IDLE;
                        rd_ptr_next = '0;
                        done_next   = 1'b1;
                    end else begin
                        rd_ptr_next = rd_ptr_reg + PTR_W'(1);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_reg     <= IDLE;
            row_ptr_reg   <= '0;
            rd_ptr_reg    <= '0;
            tile_ptr_reg  <= '0;
            num_tiles_reg <= '0;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            row_ptr_reg   <= row_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
            tile_ptr_reg  <= tile_ptr_next;
            num_tiles_reg <= num_tiles_next;
            done_reg      <= done_next;
        end
    end

    // Buffer storage carries no reset; writes are gated by the FSM only.
    always_ff @(posedge clk) begin
        if (!rst_n && acc_we) begin
            acc_buf[row_ptr_reg] <= acc_sum;
        end
    end

    assign out_valid_o = (state_reg == DRAIN);
    assign out_data_o  = (state_reg == DRAIN) ? acc_buf[rd_ptr_reg] : '0;
    assign busy_o      = (state_reg != IDLE);
    assign done_o      = done_reg;

endmodule

// File: tb/tb_psum_accumulator.sv
// Directed bench for psum_accumulator: accumulation, drain, backpressure,
// ignored inputs, reset mid-job and back-to-back jobs.
module tb_psum_accumulator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_i;
    logic [7:0]  num_tiles_i;
    logic [31:0] psum_i;
    logic        psum_en_i;
    logic [31:0] out_data_o;
    logic        out_valid_o;
    logic        out_ready_i;
    logic        busy_o;
    logic        done_o;

    int pass_count  = 0;
    int check_count = 0;
    logic [31:0] exp_q [16];

    psum_accumulator #(
        .PSUM_WIDTH(32), .ACC_WIDTH(32), .DEPTH(16), .TILE_WIDTH(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .num_tiles_i(num_tiles_i),
        .psum_i(psum_i), .psum_en_i(psum_en_i), .out_data_o(out_data_o),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [31:0] v);
        psum_en_i = 1'b1;
        psum_i    = v;
        tick();
        psum_en_i = 1'b0;
        psum_i    = 32'h0;
    endtask

    task automatic do_start(input logic [7:0] n);
        start_i     = 1'b1;
        num_tiles_i = n;
        tick();
        start_i     = 1'b0;
        num_tiles_i = 8'd0;
    endtask

    // Drains 16 rows against exp_q; optional stall at one row and optional
    // start_i held high throughout. Returns in the done_o cycle.
    task automatic drain_and_check(input string name, input int stall_row,
                                   input int stall_len, input bit start_during);
        out_ready_i = 1'b1;
        for (int r = 0; r < 16; r++) begin
            if (start_during) begin
                start_i     = 1'b1;
                num_tiles_i = 8'd5;
            end
            if (r == stall_row) begin
                out_ready_i = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    check_count++;
                    if (out_valid_o !== 1'b1 || out_data_o !== exp_q[r])
                        $display("FAIL %s stall row %0d: valid=%b data=%0h, required valid=1 data=%0h",
                                 name, r, out_valid_o, out_data_o, exp_q[r]);
                    else pass_count++;
                    tick();
                end
                out_ready_i = 1'b1;
            end
            check_count++;
            if (out_valid_o !== 1'b1 || out_data_o !== exp_q[r] || busy_o !== 1'b1)
                $display("FAIL %s row %0d: valid=%b busy=%b data=%0h, required valid=1 busy=1 data=%0h",
                         name, r, out_valid_o, busy_o, out_data_o, exp_q[r]);
            else pass_count++;
            $display("%s: row %0d data %0h", name, r, out_data_o);
            tick();
        end
        start_i     = 1'b0;
        num_tiles_i = 8'd0;
        out_ready_i = 1'b0;
        check_count++;
        if (done_o !== 1'b1 || busy_o !== 1'b0 || out_valid_o !== 1'b0)
            $display("FAIL %s done cycle: done=%b busy=%b valid=%b, required 1 0 0",
                     name, done_o, busy_o, out_valid_o);
        else pass_count++;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; start_i = 1'b0; num_tiles_i = 8'd0; psum_i = 32'h0;
        psum_en_i = 1'b0; out_ready_i = 1'b0;
        tick(); tick();
        check_count++;
        if (out_data_o !== 32'h0 || out_valid_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0)
            $display("FAIL reset: data=%0h valid=%b busy=%b done=%b, required all 0",
                     out_data_o, out_valid_o, busy_o, done_o);
        else pass_count++;
        rst_n = 1'b0;
        tick();
    endtask

    task automatic test_single_tile();
        do_start(8'd1);
        check_count++;
        if (busy_o !== 1'b1) $display("FAIL single busy after start: got %b required 1", busy_o);
        else pass_count++;
        for (int r = 0; r < 16; r++) begin
            if (r == 15) begin
                check_count++;
                if (out_valid_o !== 1'b0)
                    $display("FAIL single early valid: got %b required 0", out_valid_o);
                else pass_count++;
            end
            beat(32'(r + 1));
            exp_q[r] = 32'(r + 1);
        end
        drain_and_check("single", -1, 0, 1'b0);
        tick();
        check_count++;
        if (done_o !== 1'b0) $display("FAIL single done width: got %b required 0", done_o);
        else pass_count++;
    endtask

    task automatic test_three_tiles();
        do_start(8'd3);
        for (int t = 0; t < 3; t++)
            for (int r = 0; r < 16; r++) begin
                beat(32'(r + 1));
                check_count++;
                if (busy_o !== 1'b1) $display("FAIL three busy t%0d r%0d: got %b required 1", t, r, busy_o);
                else pass_count++;
            end
        for (int r = 0; r < 16; r++) exp_q[r] = 32'(3 * (r + 1));
        drain_and_check("three", -1, 0, 1'b0);
        tick();
    endtask

    task automatic test_backpressure_gaps();
        do_start(8'd2);
        for (int t = 0; t < 2; t++)
            for (int r = 0; r < 16; r++) begin
                int g;
                beat(32'd10);
                g = $urandom_range(1, 3);
                repeat (g) tick();
            end
        for (int r = 0; r < 16; r++) exp_q[r] = 32'd20;
        drain_and_check("bp", 2, 5, 1'b0);
        tick();
    endtask

    task automatic test_wrap();
        do_start(8'd2);
        for (int t = 0; t < 2; t++)
            for (int r = 0; r < 16; r++) beat((r == 0) ? 32'hFFFF_FFFF : 32'(r));
        exp_q[0] = 32'hFFFF_FFFE;
        for (int r = 1; r < 16; r++) exp_q[r] = 32'(2 * r);
        drain_and_check("wrap", -1, 0, 1'b0);
        tick();
    endtask

    task automatic test_ignored_inputs();
        do_start(8'd0);
        check_count++;
        if (busy_o !== 1'b0) $display("FAIL zero-tile start busy: got %b required 0", busy_o);
        else pass_count++;
        tick();
        check_count++;
        if (done_o !== 1'b0 || out_valid_o !== 1'b0)
            $display("FAIL zero-tile start done/valid: got %b/%b required 0/0", done_o, out_valid_o);
        else pass_count++;
        for (int i = 0; i < 4; i++) beat(32'hDEAD_0000 + 32'(i));
        do_start(8'd1);
        for (int r = 0; r < 16; r++) begin
            beat(32'(100 + r));
            exp_q[r] = 32'(100 + r);
        end
        drain_and_check("ignored", -1, 0, 1'b1);
        tick();
        check_count++;
        if (busy_o !== 1'b0) $display("FAIL start during drain accepted: busy=%b required 0", busy_o);
        else pass_count++;
    endtask

    task automatic test_reset_mid_job();
        do_start(8'd2);
        for (int r = 0; r < 7; r++) beat(32'd9);
        rst_n = 1'b1;
        tick();
        check_count++;
        if (out_data_o !== 32'h0 || out_valid_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0)
            $display("FAIL mid-job reset: data=%0h valid=%b busy=%b done=%b, required all 0",
                     out_data_o, out_valid_o, busy_o, done_o);
        else pass_count++;
        rst_n = 1'b0;
        do_start(8'd1);
        for (int r = 0; r < 16; r++) begin
            beat(32'd5);
            exp_q[r] = 32'd5;
        end
        drain_and_check("after_reset", -1, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        // Entered in a done cycle: the start here must be accepted.
        do_start(8'd1);
        check_count++;
        if (busy_o !== 1'b1) $display("FAIL start in done cycle: busy=%b required 1", busy_o);
        else pass_count++;
        for (int r = 0; r < 16; r++) begin
            beat(32'(7 * r + 3));
            exp_q[r] = 32'(7 * r + 3);
        end
        drain_and_check("b2b", -1, 0, 1'b0);
        tick();
    endtask

    initial begin
        test_reset();
        test_single_tile();
        test_three_tiles();
        test_backpressure_gaps();
        test_wrap();
        test_ignored_inputs();
        test_reset_mid_job();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/psum_accumulator.md
# psum_accumulator

Downstream stage of the PE systolic array: it consumes the partial-sum stream leaving the bottom PE of one array column (`psum`/`psum_en`) and accumulates it across several weight tiles into a local row buffer. After the last tile has been accumulated, it drains the finished sums through a valid/ready port to the output writeback logic. One instance sits below each array column.

## Interface
Parameters:
- `PSUM_WIDTH`, 32: width of the incoming partial sum (matches the PE psum width).
- `ACC_WIDTH`, 32: accumulator and output width; must be ≥ `PSUM_WIDTH`.
- `DEPTH`, 16: output rows per tile (buffer entries).
- `TILE_WIDTH`, 8: width of the tile-count input.

Ports:
- `clk`, input, 1: clock; all logic is on the rising edge.
- `rst_n`, input, 1: reset, synchronous and active-high (asserted = 1). The name is kept from the PE-array port convention.
- `start_i`, input, 1: start an accumulation job; sampled only in IDLE.
- `num_tiles_i`, input, `TILE_WIDTH`: number of tiles to accumulate; latched when `start_i` is accepted.
- `psum_i`, input, `PSUM_WIDTH`: partial sum from the bottom PE.
- `psum_en_i`, input, 1: `psum_i` valid this cycle (the PE `psum_en` output).
- `out_data_o`, output, `ACC_WIDTH`: accumulated result.
- `out_valid_o`, output, 1: `out_data_o` valid.
- `out_ready_i`, input, 1: downstream accepts `out_data_o`.
- `busy_o`, output, 1: high in ACCUM or DRAIN.
- `done_o`, output, 1: one-cycle pulse when the job completes.

## Operation
- FSM states: IDLE, ACCUM, DRAIN.
- **IDLE → ACCUM**: when `start_i` = 1 and `num_tiles_i` ≠ 0. On this transition:
  - latch `num_tiles_i`;
  - clear `row_ptr`, `tile_ptr` and `rd_ptr`.
- **Start ignored**: `start_i` with `num_tiles_i` = 0 is ignored (no state change, no `done_o`). `start_i` in ACCUM or DRAIN is also ignored.
- **ACCUM, per beat** (each cycle with `psum_en_i` = 1):
  - if `tile_ptr` = 0: `buf[row_ptr]` ← zero-extended `psum_i`;
  - otherwise: `buf[row_ptr]` ← `buf[row_ptr]` + zero-extended `psum_i`;
  - the addition is unsigned and wraps modulo 2^`ACC_WIDTH`; no saturation.
- **ACCUM, pointer advance**:
  - `row_ptr` increments on each beat and wraps from `DEPTH`-1 to 0;
  - on that wrap `tile_ptr` increments;
  - the beat at `row_ptr` = `DEPTH`-1 and `tile_ptr` = latched count − 1 is the last beat; it moves the FSM to DRAIN.
- **ACCUM, gaps**: cycles with `psum_en_i` = 0 change nothing.
- **`psum_en_i` outside ACCUM** is ignored; the buffer is not written.
- **DRAIN**:
  - `out_valid_o` = 1 and `out_data_o` = `buf[rd_ptr]`;
  - a handshake (`out_valid_o` & `out_ready_i`) increments `rd_ptr`;
  - the handshake at `rd_ptr` = `DEPTH`-1 returns the FSM to IDLE and sets `done_o` for the next cycle.
- **Backpressure**: while `out_ready_i` = 0, `out_data_o` and `out_valid_o` hold stable.
- **Reset** (`rst_n` = 1, including mid-ACCUM or mid-DRAIN): FSM → IDLE; all pointers 0; all outputs 0; the latched tile count is cleared. Buffer contents are not reset; tile 0 always overwrites them.

## Timing
- Reset values: `out_data_o` = 0, `out_valid_o` = 0, `busy_o` = 0, `done_o` = 0.
- `busy_o` rises the cycle after `start_i` is accepted. It falls in the same cycle that `done_o` is high.
- Last ACCUM beat at cycle t → `out_valid_o` = 1 at t+1, with `out_data_o` = `buf[0]`. All rows include every beat.
- DRAIN throughput is one result per cycle with `out_ready_i` held high, so DRAIN takes `DEPTH` cycles minimum.
- Final handshake at cycle t → `done_o` = 1 at t+1 (exactly one cycle), FSM already in IDLE.
- `start_i` asserted in the `done_o` cycle is accepted.
- Accumulate latency is one cycle: a beat written at cycle t is visible in `buf` at t+1. Back-to-back beats to the same row cannot occur when `DEPTH` ≥ 2.
- `out_data_o` may be a direct read of the flop array indexed by registered `rd_ptr`. No combinational path exists from `out_ready_i` to `out_data_o` or `out_valid_o` within a cycle.

## Test plan
1. **Single tile.** `num_tiles_i` = 1; 16 beats with `psum_i` = 1..16 → `out_data_o` sequence 1..16, `out_valid_o` first high the cycle after beat 16, `done_o` pulses once.
2. **Three tiles.** `num_tiles_i` = 3; each tile sends `psum_i` = row+1 → outputs 3, 6, …, 48; `busy_o` high from start through the final handshake.
3. **Backpressure and gaps.** `num_tiles_i` = 2, `psum_i` = 10 every beat, with random one- to three-cycle gaps in `psum_en_i`. Hold `out_ready_i` = 0 for 5 cycles at `rd_ptr` = 2 → every output is 20; the row-2 value is stable while stalled; no row is lost or duplicated.
4. **Wrap-around.** `num_tiles_i` = 2, `psum_i` = 0xFFFF_FFFF for row 0 in both tiles → `out_data_o[0]` = 0xFFFF_FFFE.
5. **Ignored inputs.** `start_i` with `num_tiles_i` = 0 → stays IDLE, no `done_o`. `psum_en_i` pulses in IDLE → buffer unaffected. `start_i` during DRAIN → ignored.
6. **Reset mid-job.** Assert reset after 7 beats of a 2-tile job → all outputs 0 next cycle. Then start `num_tiles_i` = 1 with `psum_i` = 5 → all 16 outputs are 5.
